cache_controller: RTL and testbench
===================================

# cache_controller

Direct-mapped, write-through, write-allocate cache controller with one-word lines. It sits between the CPU-side request port and the word-addressed `ram` block, and drives `ram`'s `address`, `data` and `write` inputs while consuming its `out`. Read hits are served in one cycle. Misses and all writes go to RAM and wait a fixed number of RAM cycles, set by a counter.

## Interface
Parameters:
- `INDEX_BITS`, default 5: number of lines is 2^INDEX_BITS (32 by default). Index is `req_address` low INDEX_BITS bits; the tag is the remaining 32-INDEX_BITS bits.
- `MEM_LATENCY`, default 2: RAM cycles per access. Must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request present.
- `req_write` in 1: 1 = write, 0 = read.
- `req_address` in 32: word address.
- `req_data` in 32: write data.
- `req_ready` out 1: controller can accept a request (IDLE).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_data` out 32: read data (write: echoes written word).
- `resp_hit` out 1: request hit a valid matching line.
- `mem_address` out 32: to `ram.address`.
- `mem_data` out 32: to `ram.data`.
- `mem_write` out 1: to `ram.write`.
- `mem_out` in 32: from `ram.out`.

## Operation
- Storage: per line, a valid bit, a tag of 32-INDEX_BITS bits, and a 32-bit data word. The array read is combinational; array writes are clocked.
- A request is accepted on a rising edge when `req_valid` and `req_ready` are both 1. Request fields are sampled only at acceptance.
- hit = valid[index] and tag[index] equal to the tag of `req_address`.
- States:
  - IDLE: `req_ready`=1.
    - Read hit: stay in IDLE. Respond with `resp_data`=line data, `resp_hit`=1.
    - Read miss: go to READ_MEM.
    - Write (hit or miss): update the line (valid=1, new tag, `req_data`) at acceptance, then go to WRITE_MEM. `resp_hit` reports the pre-write hit status.
  - READ_MEM: `req_ready`=0, `mem_write`=0, `mem_address`=latched address. Down-counter is loaded with MEM_LATENCY-1. When the counter is 0:
    - capture `mem_out`;
    - fill the line (valid, tag, data);
    - respond with `resp_hit`=0 and the captured data;
    - go to IDLE.
  - WRITE_MEM: `req_ready`=0, `mem_write`=1, `mem_address`/`mem_data` = latched request. Counter as in READ_MEM. At 0, respond and go to IDLE.
- No response backpressure: `resp_valid` is a pulse and the consumer must take it.
- `mem_address`/`mem_data` hold their last values in IDLE. `mem_write` is 1 only in WRITE_MEM.
- The RAM aliases addresses modulo 4096. The cache compares full 32-bit tags and does not model this aliasing.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE;
  - all valid bits 0;
  - `req_ready`=1, `resp_valid`=0, `resp_hit`=0;
  - `resp_data`, `mem_address`, `mem_data` = 0;
  - `mem_write`=0.
  - Tag and data arrays need not be cleared.
- Acceptance cycle C0; latencies counted from C0:
  - Read hit: `resp_valid` in C1. `req_ready` stays 1, so back-to-back hits give one response per cycle.
  - Read miss: READ_MEM occupies C1..C_L (L=MEM_LATENCY). `mem_out` is sampled at the end of C_L. `resp_valid` is in C_{L+1}.
  - Write: `mem_write`=1 for exactly L cycles, C1..C_L. `resp_valid` is in C_{L+1}.
- In C_{L+1} the state is IDLE and `req_ready`=1. A new request may be accepted in the same cycle as the response.
- Reset mid-READ_MEM: no fill, no response, and the line stays invalid.
- Reset mid-WRITE_MEM: `mem_write` drops immediately and no response is issued. Valid bits are cleared, so the earlier write-allocate has no effect.
- `req_valid` while `req_ready`=0 is ignored; the requester must hold it.

## Test plan
- Reset, then read address 0 → miss: `mem_address`=0 for L cycles; `resp_valid` at C_{L+1} with `resp_hit`=0. Re-read 0 → `resp_valid` in C1, `resp_hit`=1, same data.
- Write 14528 to address 0 → `mem_write` high for exactly L cycles with `mem_address`=0, `mem_data`=14528; response at C_{L+1}. Read 0 → hit in C1, `resp_data`=14528.
- Write 526421 to 0xA7E5FBDC (index 28) → then read it: hit, 526421. Write 14528 to the same address → read returns 14528 as a hit, and the RAM holds 14528.
- Conflict: with address 0 cached, read address 32 (index 0, different tag) → miss, evicts. Read 0 → miss, `resp_hit`=0, data re-fetched from RAM.
- Read 0xFFFFFFFF (index 31) and assert `rst_n`=0 during READ_MEM → no `resp_valid`, `req_ready`=1 immediately. Re-read after reset → miss again.
- Back-to-back read hits on addresses 0 and 0xA7E5FBDC with `req_valid` held high → `resp_valid` on consecutive cycles with the correct data, and `req_ready` never drops.

Source files
------------

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through write-allocate cache controller
//
// Sits between a CPU request port and a word-addressed RAM. Each line holds
// one word. Read hits return in one cycle. Read misses and all writes go to
// RAM and take MEM_LATENCY cycles there before the response.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  CPU request handshake; accepted when both are 1
//   req_write            1 = write, 0 = read
//   req_address          32-bit word address
//   req_data             write data
//   resp_valid           one-cycle response pulse
//   resp_data            read data (a write echoes the written word)
//   resp_hit             request hit a valid line with a matching tag
//   mem_address          to ram.address
//   mem_data             to ram.data
//   mem_write            to ram.write, high only while writing through
//   mem_out              from ram.out
module cache_controller #(
    parameter int INDEX_BITS  = 5,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_hit,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_write,
    input  logic [31:0] mem_out
);

    localparam int TAG_BITS = 32 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MEM  = 2'd1,
        WRITE_MEM = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]       cnt;
    logic                pend_hit;
    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  accept;
    logic                  done;

    assign req_index  = req_address[INDEX_BITS-1:0];
    assign req_tag    = req_address[31:INDEX_BITS];
    // The latched RAM address doubles as the fill address on a read miss.
    assign fill_index = mem_address[INDEX_BITS-1:0];
    assign fill_tag   = mem_address[31:INDEX_BITS];

    assign hit    = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign accept = req_valid && (state == IDLE);
    assign done   = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept && req_write) begin
                    state_next = WRITE_MEM;
                end else if (accept && !hit) begin
                    state_next = READ_MEM;
                end
            end
            READ_MEM: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            WRITE_MEM: begin
                mem_write = 1'b1;
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control, response and RAM-side registers. Valid bits live here so that
    // reset invalidates every line, undoing a write-allocate whose RAM write
    // was cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pend_hit    <= 1'b0;
            valid       <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_hit    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_write) begin
                            valid[req_index] <= 1'b1;
                            mem_address      <= req_address;
                            mem_data         <= req_data;
                            pend_hit         <= hit;
                            cnt              <= CNT_LOAD;
                        end else if (hit) begin
                            resp_valid <= 1'b1;
                            resp_data  <= data_mem[req_index];
                            resp_hit   <= 1'b1;
                        end else begin
                            mem_address <= req_address;
                            cnt         <= CNT_LOAD;
                        end
                    end
                end
                READ_MEM: begin
                    if (done) begin
                        valid[fill_index] <= 1'b1;
                        resp_valid        <= 1'b1;
                        resp_data         <= mem_out;
                        resp_hit          <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WRITE_MEM: begin
                    if (done) begin
                        resp_valid <= 1'b1;
                        resp_data  <= mem_data;
                        resp_hit   <= pend_hit;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays are not reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (accept && req_write) begin
            tag_mem[req_index]  <= req_tag;
            data_mem[req_index] <= req_data;
        end else if ((state == READ_MEM) && done) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mem_out;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write;
    logic [31:0] mem_out;

    int passed = 0;
    int total  = 0;

    cache_controller #(.INDEX_BITS(5), .MEM_LATENCY(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_address (req_address),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_hit    (resp_hit),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .mem_out     (mem_out)
    );

    always #5 clk = ~clk;

    // RAM model: 4096 words, address taken modulo 4096, combinational read,
    // clocked write. Word i starts as 32'hC0DE0000 | i.
    bit [31:0] ram [4096];
    bit        ram_inited;

    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 4096; i++) begin
                ram[i] <= 32'hC0DE_0000 | 32'(i);
            end
            ram_inited <= 1'b1;
        end else if (mem_write) begin
            ram[mem_address[11:0]] <= mem_data;
        end
    end

    assign mem_out = ram[mem_address[11:0]];

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_hit;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issues one request and follows it to its response, checking latency,
    // data, hit flag, the number of mem_write cycles and the RAM-side address
    // and data while the controller is busy.
    task automatic do_req(input string nm, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] ed,
                          input logic eh, input int el);
        int cyc;
        int wcnt;
        int bad;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_write   = w;
        req_address = a;
        req_data    = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        cyc  = 1;
        wcnt = 0;
        bad  = 0;
        while (!resp_valid && cyc < 20) begin
            if (mem_write) wcnt++;
            if (!req_ready) begin
                if (mem_address !== a) bad++;
                if (w && mem_data !== d) bad++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(el));
        chk({nm, "_data"}, resp_data, ed);
        chk({nm, "_hit"}, 32'(resp_hit), 32'(eh));
        chk({nm, "_wcycles"}, 32'(wcnt), w ? 32'd2 : 32'd0);
        chk({nm, "_membus"}, 32'(bad), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_data    = '0;

        //                w     addr           data           exp_data       hit   lat
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          32'hC0DE_0000, 1'b0, 3};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,          32'hC0DE_0000, 1'b1, 1};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'd14528,      32'd14528,     1'b1, 3};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,          32'd14528,     1'b1, 1};
        vecs[4]  = '{1'b1, 32'hA7E5_FBDC, 32'd526421,     32'd526421,    1'b0, 3};
        vecs[5]  = '{1'b0, 32'hA7E5_FBDC, 32'h0,          32'd526421,    1'b1, 1};
        vecs[6]  = '{1'b1, 32'hA7E5_FBDC, 32'd14528,      32'd14528,     1'b1, 3};
        vecs[7]  = '{1'b0, 32'hA7E5_FBDC, 32'h0,          32'd14528,     1'b1, 1};
        vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,          32'hC0DE_0020, 1'b0, 3};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,          32'd14528,     1'b0, 3};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,          32'd14528,     1'b1, 1};
        vecs[11] = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D,  32'h0BAD_F00D, 1'b1, 3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].data,
                   vecs[i].exp_data, vecs[i].exp_hit, vecs[i].exp_lat);
        end
        chk("ram_bdc", ram[12'hBDC], 32'd14528);
        chk("ram_000", ram[12'h000], 32'h0BAD_F00D);

        // Back-to-back read hits with req_valid held high
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = 32'h0000_0000;
        @(negedge clk);
        chk("b2b0_valid", 32'(resp_valid), 32'd1);
        chk("b2b0_data", resp_data, 32'h0BAD_F00D);
        chk("b2b0_hit", 32'(resp_hit), 32'd1);
        chk("b2b0_ready", 32'(req_ready), 32'd1);
        req_address = 32'hA7E5_FBDC;
        @(negedge clk);
        chk("b2b1_valid", 32'(resp_valid), 32'd1);
        chk("b2b1_data", resp_data, 32'd14528);
        chk("b2b1_hit", 32'(resp_hit), 32'd1);
        chk("b2b1_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end_valid", 32'(resp_valid), 32'd0);

        // Reset during READ_MEM
        req_valid   = 1'b1;
        req_address = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rrd_busy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rrd_ready", 32'(req_ready), 32'd1);
        chk("rrd_resp_valid", 32'(resp_valid), 32'd0);
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (resp_valid) seen++;
            end
            chk("rrd_no_resp", 32'(seen), 32'd0);
        end
        do_req("rrd_reread", 1'b0, 32'hFFFF_FFFF, 32'h0, 32'hC0DE_0FFF, 1'b0, 3);
        do_req("rrd_inval0", 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1'b0, 3);

        // Reset during WRITE_MEM: the RAM write never lands, the line is invalid
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = 32'h0000_0005;
        req_data    = 32'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        chk("rwr_busy", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rwr_mem_write", 32'(mem_write), 32'd0);
        chk("rwr_ready", 32'(req_ready), 32'd1);
        chk("rwr_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req("rwr_reread", 1'b0, 32'h0000_0005, 32'h0, 32'hC0DE_0005, 1'b0, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
